// File: rtl/tx_step_sequencer.sv
// Step-driven sequencer for the bit-serial transmitter datapath.
// Walks a stored message start bit, data bits LSB first, stop bit, done.
module tx_step_sequencer #(
    parameter int unsigned           N_EL = 4,
    parameter logic [4*N_EL-1:0]     MSG  = 16'hC5A3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       click,
    input  logic       auto_en,
    input  logic       tick,
    output logic [3:0] NOM,
    output logic [1:0] BIT,
    output logic [3:0] EL,
    output logic       TX,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [3:0] LAST = 4'(N_EL - 1);

    function automatic logic [3:0] elem(input logic [3:0] idx);
        logic [4*N_EL-1:0] s;
        s = MSG >> {idx, 2'b00};
        return s[3:0];
    endfunction

    state_e     state_q, state_d;
    logic [3:0] nom_q, nom_d;
    logic [1:0] bit_q, bit_d;
    logic [3:0] el_q, el_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       click_q;

    logic       step;
    logic [3:0] nom_inc;
    logic [1:0] bit_inc;
    logic [3:0] el_first;
    logic [3:0] el_next;

    // click_q tracks the button even in auto mode so toggling auto_en
    // can never fabricate a rising edge.
    assign step     = auto_en ? tick : (click & ~click_q);
    assign nom_inc  = nom_q + 4'd1;
    assign bit_inc  = bit_q + 2'd1;
    assign el_first = elem(4'd0);
    assign el_next  = elem(nom_inc);

    always_comb begin
        state_d = state_q;
        nom_d   = nom_q;
        bit_d   = bit_q;
        el_d    = el_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (step) begin
                    state_d = S_START;
                    nom_d   = 4'd0;
                    bit_d   = 2'd0;
                    el_d    = el_first;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_START: begin
                if (step) begin
                    state_d = S_DATA;
                    nom_d   = 4'd0;
                    bit_d   = 2'd0;
                    el_d    = el_first;
                    tx_d    = el_first[0];
                end
            end
            S_DATA: begin
                if (step) begin
                    if (bit_q != 2'd3) begin
                        bit_d = bit_inc;
                        tx_d  = el_q[bit_inc];
                    end else if (nom_q >= LAST) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        nom_d = nom_inc;
                        bit_d = 2'd0;
                        el_d  = el_next;
                        tx_d  = el_next[0];
                    end
                end
            end
            S_STOP: begin
                if (step) begin
                    state_d = S_DONE;
                    nom_d   = LAST;
                    bit_d   = 2'd3;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                if (step) begin
                    state_d = S_IDLE;
                    nom_d   = 4'd0;
                    bit_d   = 2'd0;
                    el_d    = el_first;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                nom_d   = 4'd0;
                bit_d   = 2'd0;
                el_d    = el_first;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            nom_q   <= 4'd0;
            bit_q   <= 2'd0;
            el_q    <= MSG[3:0];
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            click_q <= 1'b0;
        end else begin
            state_q <= state_d;
            nom_q   <= nom_d;
            bit_q   <= bit_d;
            el_q    <= el_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            click_q <= click;
        end
    end

    assign NOM  = nom_q;
    assign BIT  = bit_q;
    assign EL   = el_q;
    assign TX   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_tx_step_sequencer.sv
// Directed bench for tx_step_sequencer: default message and a
// single-element instance driven from separate step buttons.
module tb_tx_step_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       click_a = 1'b0;
    logic       click_b = 1'b0;
    logic       auto_en = 1'b0;
    logic       tick = 1'b0;

    logic [3:0] nom_a, el_a, nom_b, el_b;
    logic [1:0] bit_a, bit_b;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tx_step_sequencer u_a (
        .clk(clk), .rst_n(rst_n), .click(click_a),
        .auto_en(auto_en), .tick(tick),
        .NOM(nom_a), .BIT(bit_a), .EL(el_a), .TX(tx_a),
        .busy(busy_a), .done(done_a)
    );

    tx_step_sequencer #(.N_EL(1), .MSG(4'h9)) u_b (
        .clk(clk), .rst_n(rst_n), .click(click_b),
        .auto_en(1'b0), .tick(1'b0),
        .NOM(nom_b), .BIT(bit_b), .EL(el_b), .TX(tx_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input bit sel);
        @(negedge clk);
        if (sel) click_b = 1'b1; else click_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        click_a = 1'b0;
        click_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input logic [3:0] n,
                         input logic [1:0] b, input logic [3:0] e,
                         input logic t, input logic bz, input logic dn);
        chk({tag, ".NOM"}, {4'd0, nom_a}, {4'd0, n});
        chk({tag, ".BIT"}, {6'd0, bit_a}, {6'd0, b});
        chk({tag, ".EL"}, {4'd0, el_a}, {4'd0, e});
        chk({tag, ".TX"}, {7'd0, tx_a}, {7'd0, t});
        chk({tag, ".busy"}, {7'd0, busy_a}, {7'd0, bz});
        chk({tag, ".done"}, {7'd0, done_a}, {7'd0, dn});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_a("rst", 4'd0, 2'd0, 4'h3, 1'b1, 1'b0, 1'b0);
        chk("rst_b.EL", {4'd0, el_b}, 8'h09);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_a("idle_hold", 4'd0, 2'd0, 4'h3, 1'b1, 1'b0, 1'b0);

        press(0);
        chk_a("start", 4'd0, 2'd0, 4'h3, 1'b0, 1'b1, 1'b0);
        press(0);
        chk_a("d0b0", 4'd0, 2'd0, 4'h3, 1'b1, 1'b1, 1'b0);
        press(0);
        chk_a("d0b1", 4'd0, 2'd1, 4'h3, 1'b1, 1'b1, 1'b0);
        press(0);
        chk_a("d0b2", 4'd0, 2'd2, 4'h3, 1'b0, 1'b1, 1'b0);
        press(0);
        chk_a("d0b3", 4'd0, 2'd3, 4'h3, 1'b0, 1'b1, 1'b0);
        press(0);
        chk_a("d1b0", 4'd1, 2'd0, 4'hA, 1'b0, 1'b1, 1'b0);
        repeat (4) press(0);
        chk_a("d2b0", 4'd2, 2'd0, 4'h5, 1'b1, 1'b1, 1'b0);
        repeat (7) press(0);
        chk_a("d3b3", 4'd3, 2'd3, 4'hC, 1'b1, 1'b1, 1'b0);
        press(0);
        chk_a("stop", 4'd3, 2'd3, 4'hC, 1'b1, 1'b1, 1'b0);
        press(0);
        chk_a("done", 4'd3, 2'd3, 4'hC, 1'b1, 1'b0, 1'b1);
        press(0);
        chk_a("back_idle", 4'd0, 2'd0, 4'h3, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        click_a = 1'b1;
        repeat (50) @(negedge clk);
        click_a = 1'b0;
        @(negedge clk);
        chk_a("hold_one", 4'd0, 2'd0, 4'h3, 1'b0, 1'b1, 1'b0);
        press(0);
        chk_a("hold_next", 4'd0, 2'd0, 4'h3, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        auto_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            click_a = i[0];
            tick = (i % 3 == 2);
        end
        @(negedge clk);
        tick = 1'b0;
        click_a = 1'b0;
        @(negedge clk);
        chk_a("auto3", 4'd0, 2'd3, 4'h3, 1'b0, 1'b1, 1'b0);

        click_a = 1'b1;
        @(negedge clk);
        auto_en = 1'b0;
        repeat (3) @(negedge clk);
        chk_a("auto_off", 4'd0, 2'd3, 4'h3, 1'b0, 1'b1, 1'b0);
        click_a = 1'b0;
        @(negedge clk);

        press(0);
        chk_a("man_d1", 4'd1, 2'd0, 4'hA, 1'b0, 1'b1, 1'b0);
        repeat (5) press(0);
        chk_a("d2b1", 4'd2, 2'd1, 4'h5, 1'b0, 1'b1, 1'b0);

        #2 rst_n = 1'b0;
        #1;
        chk_a("async_rst", 4'd0, 2'd0, 4'h3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        press(0);
        chk_a("post_rst", 4'd0, 2'd0, 4'h3, 1'b0, 1'b1, 1'b0);

        press(1);
        chk("b_start.TX", {7'd0, tx_b}, 8'h00);
        chk("b_start.busy", {7'd0, busy_b}, 8'h01);
        press(1);
        chk("b_bit0", {7'd0, tx_b}, 8'h01);
        press(1);
        chk("b_bit1", {7'd0, tx_b}, 8'h00);
        press(1);
        chk("b_bit2", {7'd0, tx_b}, 8'h00);
        press(1);
        chk("b_bit3", {7'd0, tx_b}, 8'h01);
        chk("b_bit3.BIT", {6'd0, bit_b}, 8'h03);
        press(1);
        chk("b_stop.TX", {7'd0, tx_b}, 8'h01);
        chk("b_stop.busy", {7'd0, busy_b}, 8'h01);
        chk("b_stop.NOM", {4'd0, nom_b}, 8'h00);
        press(1);
        chk("b_done.done", {7'd0, done_b}, 8'h01);
        chk("b_done.busy", {7'd0, busy_b}, 8'h00);
        chk("b_done.BIT", {6'd0, bit_b}, 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
